// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// One shift-add (multiply) or restoring shift-subtract (divide) step per cycle.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x,
                                           input logic is_signed);
    logic signed [WIDTH-1:0] xs;
    xs = x;
    return (is_signed && (xs < 0)) ? WIDTH'(-xs) : x;
  endfunction

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x,
                                             input logic en);
    return en ? (~x + WIDTH'(1)) : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x,
                                                input logic en);
    return en ? (~x + (2*WIDTH)'(1)) : x;
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  // acc_q: running product high half / partial remainder.
  // sh_q:  multiplier bits shifting out / dividend in, quotient out.
  // mb_q:  multiplicand or divisor magnitude.
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] mb_q, mb_d;
  logic             is_div_q, is_div_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     rem_diff;
  logic [WIDTH-1:0]   acc_n, sh_n;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   res_hi, res_lo;

  always_comb begin
    mul_sum  = {1'b0, acc_q} + (sh_q[0] ? {1'b0, mb_q} : '0);
    rem_sh   = {acc_q, sh_q[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, mb_q};
    if (is_div_q) begin
      // A clear borrow bit means the trial subtraction fits: keep it.
      if (!rem_diff[WIDTH]) begin
        acc_n = rem_diff[WIDTH-1:0];
        sh_n  = {sh_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_n = {acc_q[WIDTH-2:0], sh_q[WIDTH-1]};
        sh_n  = {sh_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_n = mul_sum[WIDTH:1];
      sh_n  = {mul_sum[0], sh_q[WIDTH-1:1]};
    end

    prod = neg_2w({acc_n, sh_n}, negq_q);
    if (is_div_q) begin
      // Divide by zero leaves |A| as remainder, which the sign fix restores to A.
      res_lo = dbz_q ? '1 : neg_w(sh_n, negq_q);
      res_hi = neg_w(acc_n, negr_q);
    end else begin
      res_lo = prod[WIDTH-1:0];
      res_hi = prod[2*WIDTH-1:WIDTH];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    acc_d    = acc_q;
    sh_d     = sh_q;
    mb_d     = mb_q;
    is_div_d = is_div_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    dbz_d    = dbz_q;

    case (state_q)
      IDLE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start) begin
          state_d  = RUN;
          cnt_d    = '0;
          is_div_d = op[1];
          acc_d    = '0;
          sh_d     = mag(A, op[0]);
          mb_d     = mag(B, op[0]);
          negq_d   = op[0] & (A[WIDTH-1] ^ B[WIDTH-1]);
          negr_d   = op[0] & A[WIDTH-1];
          dbz_d    = (B == '0);
        end
      end
      RUN: begin
        acc_d = acc_n;
        sh_d  = sh_n;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          hi_d    = res_hi;
          lo_d    = res_lo;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  // Operand datapath: only meaningful while RUN, so it needs no reset.
  always_ff @(posedge clk) begin
    acc_q    <= acc_d;
    sh_q     <= sh_d;
    mb_q     <= mb_d;
    is_div_q <= is_div_d;
    negq_q   <= negq_d;
    negr_q   <= negr_d;
    dbz_q    <= dbz_d;
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: result table plus handshake, write and reset sequences.
module tb_muldiv_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start, hi_we, lo_we;
  logic [1:0]   op;
  logic [W-1:0] A, B, wdata;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int checks   = 0;
  int failures = 0;
  int cyc;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a, b, eh, el;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the start edge.
  task automatic start_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1; op = o; A = a; B = b;
    @(negedge clk);
    start = 1'b0; A = $urandom; B = $urandom; op = 2'($urandom);
  endtask

  task automatic wait_done(output int c);
    int n;
    n = 0; c = 0;
    while (done !== 1'b1 && n < 200) begin
      if (busy) c++;
      n++;
      @(negedge clk);
    end
    chk("done_seen", {31'b0, done}, 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{2'b01, 32'hFFFFFFFA, 32'hFFFFFFFD, 32'h00000000, 32'h00000012};
    vecs[1]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[2]  = '{2'b01, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF2};
    vecs[3]  = '{2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[4]  = '{2'b10, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003};
    vecs[5]  = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[6]  = '{2'b10, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF};
    vecs[7]  = '{2'b11, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
    vecs[8]  = '{2'b11, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[9]  = '{2'b00, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
    vecs[10] = '{2'b10, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};
    vecs[11] = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[12] = '{2'b11, 32'h80000000, 32'h00000001, 32'h00000000, 32'h80000000};
    vecs[13] = '{2'b10, 32'h00000009, 32'h00000003, 32'h00000000, 32'h00000003};

    reset = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'b00; A = '0; B = '0; wdata = '0;
    #1;
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_done", {31'b0, done}, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      start_op(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(cyc);
      chk($sformatf("v%0d_cycles", i), 32'(cyc), 32'd32);
      chk($sformatf("v%0d_hi", i), hi, vecs[i].eh);
      chk($sformatf("v%0d_lo", i), lo, vecs[i].el);
      @(negedge clk);
      chk($sformatf("v%0d_done_1cyc", i), {31'b0, done}, 32'h0);
    end

    // Idle MTHI/MTLO writes
    hi_we = 1'b1; wdata = 32'h00001234;
    @(negedge clk);
    hi_we = 1'b0;
    chk("mthi_hi", hi, 32'h00001234);
    chk("mthi_lo_held", lo, 32'h00000003);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0000ABCD;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    chk("both_hi", hi, 32'h0000ABCD);
    chk("both_lo", lo, 32'h0000ABCD);
    hi_we = 1'b1; wdata = 32'h00001234;
    @(negedge clk);
    hi_we = 1'b0;
    chk("mthi2_hi", hi, 32'h00001234);

    // Start and MTHI during busy cycle 5 are ignored
    start_op(2'b00, 32'd3, 32'd4);
    repeat (4) @(negedge clk);
    start = 1'b1; op = 2'b10; A = 32'd100; B = 32'd7; hi_we = 1'b1; wdata = 32'hDEAD0000;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0;
    chk("busy_hi_held", hi, 32'h00001234);
    chk("busy_still", {31'b0, busy}, 32'h1);
    wait_done(cyc);
    chk("ign_cycles", 32'(cyc + 5), 32'd32);
    chk("ign_hi", hi, 32'h0);
    chk("ign_lo", lo, 32'd12);
    @(negedge clk);
    chk("ign_no_restart", {31'b0, busy}, 32'h0);

    // Start with simultaneous MTHI/MTLO: write lands, result overwrites later
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h55555555;
    start_op(2'b11, 32'hFFFFFF9C, 32'd7);
    hi_we = 1'b0; lo_we = 1'b0;
    chk("sw_hi", hi, 32'h55555555);
    chk("sw_lo", lo, 32'h55555555);
    wait_done(cyc);
    chk("sw_cycles", 32'(cyc), 32'd32);
    chk("sw_res_hi", hi, 32'hFFFFFFFE);
    chk("sw_res_lo", lo, 32'hFFFFFFF2);

    // Back-to-back: second start issued in the done cycle
    @(negedge clk);
    start_op(2'b00, 32'h00001234, 32'h00000010);
    wait_done(cyc);
    chk("b2b1_hi", hi, 32'h0);
    chk("b2b1_lo", lo, 32'h00012340);
    start_op(2'b10, 32'd100, 32'd7);
    wait_done(cyc);
    chk("b2b2_cycles", 32'(cyc), 32'd32);
    chk("b2b2_hi", hi, 32'd2);
    chk("b2b2_lo", lo, 32'd14);

    // Asynchronous reset mid-divide
    @(negedge clk);
    start_op(2'b11, 32'hFFFFFFF0, 32'd3);
    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_hi", hi, 32'h0);
    chk("arst_lo", lo, 32'h0);
    chk("arst_busy", {31'b0, busy}, 32'h0);
    chk("arst_done", {31'b0, done}, 32'h0);
    repeat (2) begin
      @(negedge clk);
      chk("arst_no_done", {31'b0, done}, 32'h0);
    end
    reset = 1'b0;
    @(negedge clk);
    chk("arst_idle", {31'b0, busy}, 32'h0);
    start_op(2'b10, 32'd9, 32'd3);
    wait_done(cyc);
    chk("post_cycles", 32'(cyc), 32'd32);
    chk("post_hi", hi, 32'h0);
    chk("post_lo", lo, 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
